// File: rtl/gf2m_digit_mul_if.sv
// Operand/result bundle for the digit-serial GF(2^M) multiplier.
// The master drives the request and operands; the slave returns status and the product.
interface gf2m_digit_mul_if #(
    parameter int M = 163
);
    logic         start;
    logic         abort;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] poly;
    logic         busy;
    logic         done;
    logic [M-1:0] result;

    modport master (
        output start, abort, a, b, poly,
        input  busy, done, result
    );

    modport slave (
        input  start, abort, a, b, poly,
        output busy, done, result
    );
endinterface

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, result = a*b mod (x^M + poly).
// Consumes D bits of b per cycle, MSB digit first (Horner), with abort and back-to-back restart.
module gf2m_digit_mul #(
    parameter int M = 163,
    parameter int D = 32
) (
    input  logic              clk,
    input  logic              rst,
    gf2m_digit_mul_if.slave   bus
);
    localparam int NDIG = (M + D - 1) / D;
    localparam int W    = NDIG * D;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic {IDLE, CAL} state_t;

    state_t         state;
    state_t         state_next;
    logic [M-1:0]   a_reg;
    logic [M-1:0]   poly_reg;
    logic [W-1:0]   b_reg;
    logic [M-1:0]   acc;
    logic [M-1:0]   acc_next;
    logic [CW-1:0]  dcnt;
    logic           done_q;
    logic [M-1:0]   result_q;
    logic           load;
    logic           step;
    logic           finish;
    logic [D-1:0]   digit;

    function automatic logic [M-1:0] xtime(input logic [M-1:0] t, input logic [M-1:0] p);
        logic [M-1:0] s;
        s = t << 1;
        return t[M-1] ? (s ^ p) : s;
    endfunction

    // One full digit of Horner steps per cycle; padded zero digits only shift acc.
    always_comb begin
        digit    = b_reg[W-1 -: D];
        acc_next = acc;
        for (int j = D - 1; j >= 0; j--) begin
            acc_next = xtime(acc_next, poly_reg) ^ (digit[j] ? a_reg : '0);
        end
    end

    // Abort overrides any start or completion in the same cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        load       = 1'b1;
                        state_next = CAL;
                    end
                end
                CAL: begin
                    step = 1'b1;
                    if (dcnt == CW'(NDIG - 1)) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            poly_reg <= '0;
            b_reg    <= '0;
            acc      <= '0;
            dcnt     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= finish;
            if (load) begin
                a_reg    <= bus.a;
                poly_reg <= bus.poly;
                b_reg    <= W'(bus.b);
                acc      <= '0;
                dcnt     <= '0;
            end else if (step) begin
                acc   <= acc_next;
                b_reg <= b_reg << D;
                dcnt  <= dcnt + CW'(1);
                if (finish) begin
                    result_q <= acc_next;
                end
            end
        end
    end

    assign bus.busy   = (state == CAL);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
